// File: rtl/video_ts_dram_arb_pkg.sv
// Shared video definitions for the TS DRAM read-channel arbiter.
// Owner encodings, FSM states, burst default and DRAM address width.
package video_ts_dram_arb_pkg;

    localparam int VID_AW    = 21;
    localparam int BURST_DEF = 8;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_TM   = 2'b01;
    localparam logic [1:0] OWN_GFX  = 2'b10;

    // State codes equal the owner codes so owner can mirror state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TM   = 2'b01,
        ST_GFX  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/video_ts_dram_arb.sv
// TS video DRAM read-channel arbiter: tilemap prefetch vs renderer fetch.
// Burst-locked round-robin, TM urgency override, per-line word budget.
module video_ts_dram_arb
    import video_ts_dram_arb_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    parameter int BW    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic [BW-1:0]     words_max,
    input  logic              tm_urgent,
    input  logic              tm_req,
    input  logic [VID_AW-1:0] tm_addr,
    output logic              tm_next,
    input  logic              gfx_req,
    input  logic [VID_AW-1:0] gfx_addr,
    output logic              gfx_next,
    output logic              mem_req,
    output logic [VID_AW-1:0] mem_addr,
    input  logic              mem_next,
    output logic [1:0]        owner,
    output logic [BW-1:0]     words_used,
    output logic              budget_hit
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_e    state_q;
    arb_state_e    state_d;
    arb_state_e    win;
    logic [1:0]    last_q;
    logic [1:0]    tie_last;
    logic [CW-1:0] burst_q;
    logic [BW-1:0] used_q;
    logic [BW-1:0] budget_q;
    logic [BW:0]   used_inc;
    logic          hit_q;
    logic          own_req;
    logic          burst_end;
    logic          rearb;

    function automatic arb_state_e arb(
        input logic       urg,
        input logic       tm_r,
        input logic       gfx_r,
        input logic [1:0] last
    );
        if (urg && tm_r)
            return ST_TM;
        if (tm_r && gfx_r)
            return (last == OWN_TM) ? ST_GFX : ST_TM;
        if (tm_r)
            return ST_TM;
        if (gfx_r)
            return ST_GFX;
        return ST_IDLE;
    endfunction

    assign used_inc = {1'b0, used_q} + (BW+1)'(1);

    // Grant decision: the tie breaks against the outgoing owner.
    always_comb begin
        own_req   = (state_q == ST_TM  && tm_req)
                 || (state_q == ST_GFX && gfx_req);
        burst_end = mem_next && (burst_q == CW'(BURST - 1));
        rearb     = (state_q != ST_IDLE)
                 && (!own_req || burst_end);
        tie_last  = (state_q == ST_IDLE) ? last_q : state_q;
        win       = arb(tm_urgent, tm_req, gfx_req, tie_last);
        state_d   = state_q;
        if (state_q == ST_IDLE || rearb)
            state_d = win;
        if (line_start)
            state_d = ST_IDLE;
    end

    // Route address and word strobes to the current owner only.
    always_comb begin
        mem_addr = '0;
        tm_next  = 1'b0;
        gfx_next = 1'b0;
        unique case (state_q)
            ST_TM: begin
                mem_addr = tm_addr;
                tm_next  = mem_next;
            end
            ST_GFX: begin
                mem_addr = gfx_addr;
                gfx_next = mem_next;
            end
            default: ;
        endcase
    end

    assign mem_req    = own_req && !hit_q;
    assign owner      = state_q;
    assign words_used = used_q;
    assign budget_hit = hit_q;

    // Ownership state, burst word count and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= OWN_GFX;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            if (line_start) begin
                burst_q <= '0;
            end else if (rearb) begin
                burst_q <= '0;
                last_q  <= state_q;
            end else if (mem_next && state_q != ST_IDLE) begin
                burst_q <= burst_q + CW'(1);
            end
        end
    end

    // Per-line budget: saturating word count and sticky limit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q   <= '0;
            budget_q <= '0;
            hit_q    <= 1'b0;
        end else if (line_start) begin
            used_q   <= '0;
            budget_q <= words_max;
            hit_q    <= 1'b0;
        end else begin
            if (mem_next && used_q != '1)
                used_q <= used_q + BW'(1);
            if (mem_next && used_inc == {1'b0, budget_q})
                hit_q <= 1'b1;
            if (budget_q == '0)
                hit_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_ts_dram_arb.sv
// Directed bench for video_ts_dram_arb with a cycle-level model.
// Outputs compared every cycle plus hand-computed scenario checks.
module tb_video_ts_dram_arb;
    import video_ts_dram_arb_pkg::*;

    localparam int BURST    = 8;
    localparam int BW       = 10;
    localparam int USED_MAX = (1 << BW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              line_start = 1'b0;
    logic [BW-1:0]     words_max = '0;
    logic              tm_urgent = 1'b0;
    logic              tm_req = 1'b0;
    logic [VID_AW-1:0] tm_addr = 21'h0A5A5A;
    logic              tm_next;
    logic              gfx_req = 1'b0;
    logic [VID_AW-1:0] gfx_addr = 21'h15F00F;
    logic              gfx_next;
    logic              mem_req;
    logic [VID_AW-1:0] mem_addr;
    logic              mem_next;
    logic              mem_rdy = 1'b1;
    logic [1:0]        owner;
    logic [BW-1:0]     words_used;
    logic              budget_hit;

    // Memory controller accepts a word whenever one is requested.
    assign mem_next = mem_req & mem_rdy;

    video_ts_dram_arb #(.BURST(BURST), .BW(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .words_max  (words_max),
        .tm_urgent  (tm_urgent),
        .tm_req     (tm_req),
        .tm_addr    (tm_addr),
        .tm_next    (tm_next),
        .gfx_req    (gfx_req),
        .gfx_addr   (gfx_addr),
        .gfx_next   (gfx_next),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_next   (mem_next),
        .owner      (owner),
        .words_used (words_used),
        .budget_hit (budget_hit)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // model: 0 none, 1 TM, 2 GFX
    int m_own, m_last, m_inb, m_used, m_hit, m_budget;

    int s_owner, s_req, s_tmn, s_gfn, s_used, s_hit;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_last = 2; m_inb = 0;
        m_used = 0; m_hit = 0; m_budget = 0;
    endtask

    function automatic int pick(input int prev);
        if (tm_urgent && tm_req) return 1;
        if (tm_req && gfx_req) return (prev == 1) ? 2 : 1;
        if (tm_req) return 1;
        if (gfx_req) return 2;
        return 0;
    endfunction

    task automatic model_step(input logic nx);
        int wants;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (line_start) begin
            m_own = 0; m_inb = 0; m_used = 0; m_hit = 0;
            m_budget = int'(words_max);
            return;
        end
        if (nx) begin
            if (m_used + 1 == m_budget) m_hit = 1;
            if (m_used < USED_MAX) m_used++;
        end
        if (m_budget == 0) m_hit = 1;
        if (m_own == 0) begin
            m_own = pick(m_last);
        end else begin
            wants = (m_own == 1) ? int'(tm_req) : int'(gfx_req);
            if (nx) m_inb++;
            if (wants == 0 || m_inb == BURST) begin
                m_last = m_own;
                m_own  = pick(m_own);
                m_inb  = 0;
            end
        end
    endtask

    task automatic compare_all();
        int e_req, e_addr;
        e_req = ((m_own == 1 && tm_req) || (m_own == 2 && gfx_req))
                && (m_hit == 0) ? 1 : 0;
        e_addr = (m_own == 1) ? int'(tm_addr)
               : (m_own == 2) ? int'(gfx_addr) : 0;
        chk("owner", int'(owner), m_own);
        chk("mem_req", int'(mem_req), e_req);
        chk("mem_addr", int'(mem_addr), e_addr);
        chk("tm_next", int'(tm_next), (mem_next && m_own == 1) ? 1 : 0);
        chk("gfx_next", int'(gfx_next), (mem_next && m_own == 2) ? 1 : 0);
        chk("words_used", int'(words_used), m_used);
        chk("budget_hit", int'(budget_hit), m_hit);
    endtask

    // One clock: check mid-cycle, snapshot, advance the model.
    task automatic tick();
        logic nx;
        @(negedge clk);
        compare_all();
        s_owner = int'(owner);
        s_req   = int'(mem_req);
        s_tmn   = int'(tm_next);
        s_gfn   = int'(gfx_next);
        s_used  = int'(words_used);
        s_hit   = int'(budget_hit);
        nx      = mem_next;
        @(posedge clk);
        model_step(nx);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, gaps, gfxs, seq_bad, g, nxt, t, done, first_hit;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("rst_owner", s_owner, 0);
        chk("rst_req", s_req, 0);
        chk("rst_used", s_used, 0);
        chk("rst_hit", s_hit, 0);
        rst_n = 1'b1;
        tick();

        // Single TM requester
        words_max = 10'd100;
        tm_req = 1'b1;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        chk("tm_idle_lat", s_req, 0);
        gaps = 0; cnt = 0; gfxs = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (s_req == 0) gaps++;
            if (s_tmn != 0) cnt++;
            if (s_gfn != 0) gfxs++;
        end
        chk("tm_gaps", gaps, 0);
        chk("tm_strobes", cnt, 24);
        chk("tm_gfx_none", gfxs, 0);
        tick();
        chk("tm_used24", s_used, 24);

        // Async reset mid-burst
        chk("pre_rst_owner", int'(owner), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_owner", int'(owner), 0);
        chk("arst_req", int'(mem_req), 0);
        chk("arst_tmn", int'(tm_next), 0);
        chk("arst_addr", int'(mem_addr), 0);
        chk("arst_used", int'(words_used), 0);
        chk("arst_hit", int'(budget_hit), 0);
        tm_req = 1'b0;
        tick();
        rst_n = 1'b1;

        // Contention: alternating 8-word bursts
        words_max = 10'd1000;
        tm_req = 1'b1;
        gfx_req = 1'b1;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        seq_bad = 0; cnt = 0;
        for (int k = 0; k < 48; k++) begin
            tick();
            if (s_tmn != 0 || s_gfn != 0) cnt++;
            if (s_owner != (((k / 8) % 2 == 0) ? 1 : 2)) seq_bad++;
        end
        chk("rr_sequence", seq_bad, 0);
        chk("rr_strobes", cnt, 48);
        tick();
        chk("rr_used48", s_used, 48);

        // Urgency raised while GFX is mid-burst
        g = 0;
        for (int i = 0; i < 40 && g < 3; i++) begin
            tick();
            if (s_gfn != 0) g++;
        end
        chk("urg_gfx_pre", g, 3);
        tm_urgent = 1'b1;
        nxt = 0;
        for (int i = 0; i < 20 && nxt == 0; i++) begin
            tick();
            if (s_owner == 2 && s_gfn != 0) g++;
            else if (s_owner != 2) nxt = s_owner;
        end
        chk("urg_gfx_full", g, 8);
        chk("urg_next_tm", nxt, 1);
        tm_urgent = 1'b0;

        // Urgency overrides round-robin from idle (last owner TM)
        tm_req = 1'b0;
        gfx_req = 1'b0;
        tick();
        tick();
        chk("urg_idle", s_owner, 0);
        tm_req = 1'b1;
        gfx_req = 1'b1;
        tm_urgent = 1'b1;
        tick();
        tm_urgent = 1'b0;
        tick();
        chk("urg_idle_tm", s_owner, 1);

        // Owner drops request
        tm_req = 1'b0;
        tick();
        tm_req = 1'b1;
        tick();
        chk("drop_gfx_own", s_owner, 2);
        g = s_gfn;
        tick();
        g += s_gfn;
        tick();
        g += s_gfn;
        chk("drop_gfx3", g, 3);
        gfx_req = 1'b0;
        tick();
        tick();
        chk("drop_to_tm", s_owner, 1);
        t = s_tmn;
        gfx_req = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && done == 0; i++) begin
            tick();
            if (s_owner == 1) t += s_tmn;
            else done = 1;
        end
        chk("drop_tm_burst8", t, 8);

        // line_start coincident with a GFX strobe
        words_max = 10'd5;
        line_start = 1'b1;
        tick();
        chk("ls_routed", s_gfn, 1);
        line_start = 1'b0;
        gfx_req = 1'b0;
        tm_req = 1'b1;
        tick();
        chk("ls_idle", s_owner, 0);
        chk("ls_used0", s_used, 0);

        // Budget of 5 words
        cnt = 0;
        first_hit = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_hit != 0 && first_hit < 0) first_hit = cnt;
            if (s_tmn != 0) cnt++;
        end
        chk("bud_strobes", cnt, 5);
        chk("bud_hit_after5", first_hit, 5);
        chk("bud_hit", s_hit, 1);
        chk("bud_req_low", s_req, 0);
        chk("bud_used", s_used, 5);

        // Budget of zero
        words_max = 10'd0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_req != 0) cnt++;
        end
        chk("zero_req_never", cnt, 0);
        chk("zero_hit", s_hit, 1);
        chk("zero_owner_held", s_owner, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
